clt_gauss_accum: RTL and testbench
==================================

# clt_gauss_accum

Central-limit Gaussian approximator that sits directly downstream of the Tausworthe uniform generator in the AWGN chain. It takes the upper UW bits of each valid 32-bit uniform word and sums N = 2^LOG2N of them. It removes the mean and emits one signed, approximately Gaussian sample per N accepted inputs through a valid/ready output register. The upstream URNG is free-running and has no backpressure, so any input the block cannot accept is dropped and counted.

## Interface

Parameters:
- UW, 16: uniform bits taken per input word, rnd_in[31:32-UW]; range 1..32.
- LOG2N, 4: log2 of the number of samples summed per output; range 1..8.
- OW, UW+LOG2N: derived output width; not overridable.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset. It is sampled on the rising edge of clock.
- rnd_in, input, 32: uniform word from the URNG.
- rnd_valid, input, 1: rnd_in is valid this cycle. There is no ready back to the source.
- out_data, output, OW: signed two's-complement Gaussian sample.
- out_valid, output, 1: out_data holds an unconsumed sample.
- out_ready, input, 1: consumer accepts out_data this cycle.
- drop_cnt, output, 16: saturating count of inputs that were valid but not accepted.

## Operation

State:
- acc: unsigned sum register, OW bits.
- cnt: sample counter, LOG2N bits, range 0..N-1.
- Output register: out_data and out_valid.
- drop_cnt.

Per-cycle definitions:
- u = rnd_in[31:32-UW], zero-extended to OW bits.
- last = (cnt == N-1).
- blocked = last && out_valid && !out_ready.
- accept = rnd_valid && !blocked.

On accept with !last:
- acc <= acc + u.
- cnt <= cnt + 1.

On accept with last:
- sum = acc + u. This cannot overflow, because the maximum is 2^OW - N.
- out_data <= {~sum[OW-1], sum[OW-2:0]}. This subtracts the mean N·2^(UW-1) by flipping the MSB.
- out_valid <= 1, acc <= 0, cnt <= 0.

On rnd_valid && blocked:
- The input is discarded; acc and cnt hold.
- drop_cnt <= drop_cnt + 1, saturating at 16'hFFFF.

Output handshake:
- If out_valid && out_ready and no new result is loaded the same cycle, out_valid <= 0.
- Simultaneous consume and load: out_valid stays 1 and out_data takes the new value. Nothing is lost.
- out_data is held stable while out_valid && !out_ready.

Output range: -2^(OW-1) .. 2^(OW-1) - N. The output is never saturated.

## Timing

- Reset values (reset_n low at a clock edge): acc=0, cnt=0, out_valid=0, out_data=0, drop_cnt=0.
- Reset mid-accumulation discards the partial sum. The next output needs N fresh accepted inputs after reset_n returns high.
- Latency: out_valid rises in the cycle after the edge that accepted the Nth sample.
- Throughput: one output per N cycles with continuous rnd_valid and out_ready held high.
- Non-last samples are always accepted, even while out_valid is stalled. Only the Nth sample can be blocked.
- rnd_valid low: acc and cnt hold. Gaps in rnd_valid are allowed anywhere.
- out_ready is ignored while out_valid is 0.
- There is no combinational path from any input to any output.

## Structure

- Shared package awgn_pkg:
  - URNG_W = 32.
  - Default UW and LOG2N constants.
  - Typedef for the OW-bit Gaussian sample type, which later Box-Muller/CLT comparison stages reuse.
- Single module; no sub-module is warranted. The accumulator, counter and output register form one tight unit.

## Test plan

Configuration for all scenarios: UW=16, LOG2N=4, OW=20.

- All-mid: 16 inputs of 32'h8000_0000 with out_ready=1 → one output 20'h00000, out_valid high exactly one cycle after the 16th input.
- Extremes:
  - 16 inputs of 32'hFFFF_xxxx → 20'h7FFF0 (+524272).
  - 16 inputs of 32'h0000_xxxx → 20'h80000 (-524288).
  - The low 16 bits must have no effect.
- Back-to-back with gaps: 48 inputs, rnd_valid toggling every other cycle, out_ready=1 → exactly 3 outputs, each equal to the mean-removed sum of its 16 inputs; drop_cnt=0.
- Backpressure:
  - out_ready=0, continuous rnd_valid with constant word 32'h8001_0000.
  - First output 20'h00010 stays stable and out_valid stays 1.
  - Inputs 17..31 are accepted; input 32 onward is dropped and drop_cnt increments by 1 per cycle.
  - Raise out_ready for one cycle: the held sample is consumed and the next sample (20'h00010) loads in the same edge, with out_valid still 1.
- Reset mid-operation:
  - Feed 7 inputs, then hold reset_n=0 for one edge.
  - Then 16 inputs of 32'h8000_0000 → a single output of 20'h00000 after the 16th. All outputs read 0 during reset.
- drop_cnt saturation: hold out_valid stalled for more than 65550 valid cycles → drop_cnt sticks at 16'hFFFF.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared constants and types for the AWGN chain: URNG word width, default CLT
// configuration and the Gaussian sample type reused by later comparison stages.
package awgn_pkg;

  localparam int URNG_W    = 32;
  localparam int UW_DEF    = 16;
  localparam int LOG2N_DEF = 4;
  localparam int OW_DEF    = UW_DEF + LOG2N_DEF;

  typedef logic signed [OW_DEF-1:0] gauss_sample_t;

endpackage

// File: rtl/clt_gauss_accum.sv
// Central-limit Gaussian approximator: sums 2^LOG2N uniform words, removes the
// mean by flipping the MSB and presents the result through a valid/ready register.
module clt_gauss_accum
  import awgn_pkg::*;
#(
  parameter int  UW    = UW_DEF,
  parameter int  LOG2N = LOG2N_DEF,
  localparam int OW    = UW + LOG2N
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [URNG_W-1:0]    rnd_in,
  input  logic                 rnd_valid,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          drop_cnt
);

  localparam int N = 1 << LOG2N;

  logic [OW-1:0]    acc_q, acc_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      drop_q, drop_d;

  logic [OW-1:0]    u_s;
  logic [OW-1:0]    sum_s;
  logic             last_s;
  logic             blocked_s;
  logic             accept_s;

  assign u_s       = {{LOG2N{1'b0}}, rnd_in[URNG_W-1 -: UW]};
  assign sum_s     = acc_q + u_s;
  assign last_s    = (cnt_q == LOG2N'(N - 1));
  assign blocked_s = last_s && out_valid_q && !out_ready;
  assign accept_s  = rnd_valid && !blocked_s;

  // The low word bits carry no information for this stage.
  generate
    if (UW < URNG_W) begin : g_unused_low
      logic unused_low_s;
      assign unused_low_s = ^rnd_in[URNG_W-1-UW:0];
    end
  endgenerate

  // Next-state: accumulate, load the output on the Nth sample, handshake, drops.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;

    if (accept_s && last_s) begin
      // Flipping the MSB subtracts N*2^(UW-1) exactly.
      out_data_d  = {~sum_s[OW-1], sum_s[OW-2:0]};
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (accept_s) begin
      acc_d = sum_s;
      cnt_d = cnt_q + LOG2N'(1);
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (rnd_valid && blocked_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 16'd0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_clt_gauss_accum.sv
// Self-checking bench for clt_gauss_accum (UW=16, LOG2N=4): constant-word table,
// hand sequences for gaps/backpressure/reset/saturation, random traffic vs a model.
module tb_clt_gauss_accum;

  localparam int UW    = 16;
  localparam int LOG2N = 4;
  localparam int OW    = 20;
  localparam int N     = 16;
  localparam int MEAN  = N * 32768;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   rnd_in = 32'd0;
  logic          rnd_valid = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: count of samples gathered, their integer sum, output.
  int m_cnt = 0;
  int m_sum = 0;
  bit m_valid = 1'b0;
  int m_out = 0;
  int m_drop = 0;

  clt_gauss_accum #(.UW(UW), .LOG2N(LOG2N)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] word;
    bit          rand_low;
    logic [19:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after it.
  task automatic step(input logic rv, input logic [31:0] w, input logic rdy, input logic rst);
    int  u;
    bit  loaded;
    bit  blocked;
    int  act_data;
    rnd_valid = rv;
    rnd_in    = w;
    out_ready = rdy;
    reset_n   = rst;
    @(posedge clock);
    if (!rst) begin
      m_cnt = 0; m_sum = 0; m_valid = 1'b0; m_out = 0; m_drop = 0;
    end else begin
      u       = int'(w[31:16]);
      blocked = (m_cnt == N - 1) && m_valid && !rdy;
      loaded  = 1'b0;
      if (rv && !blocked) begin
        m_sum += u;
        m_cnt++;
        if (m_cnt == N) begin
          m_out   = m_sum - MEAN;
          m_valid = 1'b1;
          m_sum   = 0;
          m_cnt   = 0;
          loaded  = 1'b1;
        end
      end
      if (!loaded && m_valid && rdy) m_valid = 1'b0;
      if (rv && blocked && m_drop < 65535) m_drop++;
    end
    #1;
    act_data = int'($signed(out_data));
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_data", act_data, m_out);
    check("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  vec_t vecs[4];

  initial begin
    int outs;
    logic [31:0] w;

    vecs[0] = '{name: "all_mid",  word: 32'h8000_0000, rand_low: 1'b0, exp: 20'h00000};
    vecs[1] = '{name: "all_max",  word: 32'hFFFF_0000, rand_low: 1'b1, exp: 20'h7FFF0};
    vecs[2] = '{name: "all_min",  word: 32'h0000_0000, rand_low: 1'b1, exp: 20'h80000};
    vecs[3] = '{name: "mid_plus", word: 32'h8001_0000, rand_low: 1'b0, exp: 20'h00010};

    // Reset state
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    check("reset_data", int'(out_data), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_drop", int'(drop_cnt), 0);

    // Constant-word table: 16 inputs each, output exactly after the 16th
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        w = vecs[v].word;
        if (vecs[v].rand_low) w[15:0] = 16'($urandom);
        step(1'b1, w, 1'b1, 1'b1);
        if (i == N - 2) check({vecs[v].name, "_early"}, int'(out_valid), 0);
      end
      check({vecs[v].name, "_valid"}, int'(out_valid), 1);
      check({vecs[v].name, "_data"}, int'(out_data), int'(vecs[v].exp));
    end
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("consumed", int'(out_valid), 0);

    // Gaps: 48 inputs on alternate cycles
    outs = 0;
    for (int i = 0; i < 96; i++) begin
      step(i[0] == 1'b0, $urandom, 1'b1, 1'b1);
      if (out_valid) outs++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b1);
    check("gap_outputs", outs, 3);
    check("gap_drops", int'(drop_cnt), 0);

    // Backpressure
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 32'h8001_0000, 1'b0, 1'b1);
      if (i >= N) begin
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_data", int'(out_data), 20'h00010);
      end
      if (i == 31) check("bp_no_drop_yet", int'(drop_cnt), 0);
    end
    check("bp_drops", int'(drop_cnt), 9);
    step(1'b1, 32'h8001_0000, 1'b1, 1'b1);
    check("bp_reload_valid", int'(out_valid), 1);
    check("bp_reload_data", int'(out_data), 20'h00010);
    check("bp_reload_drops", int'(drop_cnt), 9);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("bp_drain", int'(out_valid), 0);

    // Reset mid-accumulation
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_0000, 1'b1, 1'b0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_drop", int'(drop_cnt), 0);
    for (int i = 0; i < N; i++) begin
      step(1'b1, 32'h8000_0000, 1'b1, 1'b1);
      if (i < N - 1) check("mid_rst_early", int'(out_valid), 0);
    end
    check("mid_rst_out_valid", int'(out_valid), 1);
    check("mid_rst_out_data", int'(out_data), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Saturation of drop_cnt under a permanent stall
    step(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65600; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    check("drop_sat", int'(drop_cnt), 16'hFFFF);
    check("sat_valid", int'(out_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
